// File: rtl/parity_frame_if.sv
// Streaming beat and frame-result bundle for parity_frame.
// master drives beats and controls; slave (the checker) returns parity status.
interface parity_frame_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERR_W = 8
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             odd_mode;
    logic             out;
    logic             frame_valid;
    logic             frame_ok;
    logic [ERR_W-1:0] err_count;

    modport master (
        output clear, in_valid, in_data, odd_mode,
        input  out, frame_valid, frame_ok, err_count
    );

    modport slave (
        input  clear, in_valid, in_data, odd_mode,
        output out, frame_valid, frame_ok, err_count
    );
endinterface

// File: rtl/parity_frame.sv
// Framed even/odd parity checker: FRAME_LEN data beats, then one parity beat.
// Optional saturating failed-frame counter is built when PARITY_FRAME_ERRCNT_EN is defined.
module parity_frame #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned ERR_W     = 8
) (
    input  logic           clk,
    input  logic           reset,
    parity_frame_if.slave  bus
);
    localparam int unsigned      CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);

    // One-hot so that any corrupted encoding is detectable and recoverable
    typedef enum logic [1:0] {
        ST_DATA = 2'b01,
        ST_PAR  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             fv_q, fv_d;
    logic             ok_q, ok_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DATA;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            fv_q    <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fv_q    <= fv_d;
            ok_q    <= ok_d;
        end
    end

    // Next-state and frame result; clear wins over any beat in the same cycle
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fv_d    = 1'b0;
        ok_d    = ok_q;
        if (bus.clear) begin
            state_d = ST_DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bus.in_valid) begin
                        if (cnt_q == '0) mode_d = bus.odd_mode;
                        acc_d = acc_q ^ (^bus.in_data);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_DATA) state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    if (bus.in_valid) begin
                        fv_d    = 1'b1;
                        ok_d    = ((acc_q ^ bus.in_data[0]) == mode_q);
                        acc_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    state_d = ST_DATA;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.out         = ~acc_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_ok    = ok_q;

`ifdef PARITY_FRAME_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Saturating count of failed frames, updated with the frame_valid pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (fv_d && !ok_d && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = ERR_W'(0);
`endif

endmodule

// File: tb/tb_parity_frame.sv
// Randomised scoreboard bench for parity_frame against a beat-list parity model.
module tb_parity_frame;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned ERR_W     = 2;
    localparam int          ERR_MAX   = 3;

    typedef struct {
        bit out;
        bit fv;
        bit ok;
        int err;
    } cyc_t;

    typedef struct {
        bit ok;
        int err;
    } frm_t;

    logic clk;
    logic reset;

    parity_frame_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    parity_frame #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cyc_t cyc_q[$];
    frm_t frm_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state: ones seen so far in the frame, beats seen, latched mode
    int m_ones;
    int m_beats;
    bit m_mode;
    bit m_ok;
    int m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ones  = 0;
        m_beats = 0;
        m_mode  = 1'b0;
        m_ok    = 1'b0;
        m_err   = 0;
    endtask

    // Drive one cycle and push the expected post-edge view
    task automatic step(input bit v, input logic [7:0] d, input bit om, input bit clr);
        bit   fv;
        bit   ok;
        cyc_t c;
        frm_t f;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.odd_mode = om;
        bus.clear    = clr;
        fv = 1'b0;
        if (clr) begin
            m_ones  = 0;
            m_beats = 0;
        end else if (v) begin
            if (m_beats < FRAME_LEN) begin
                if (m_beats == 0) m_mode = om;
                m_ones  += $countones(d);
                m_beats++;
            end else begin
                ok = (((m_ones + int'(d[0])) % 2) == int'(m_mode));
                m_ok = ok;
`ifdef PARITY_FRAME_ERRCNT_EN
                if (!ok && m_err < ERR_MAX) m_err++;
`endif
                f.ok  = ok;
                f.err = m_err;
                frm_q.push_back(f);
                fv      = 1'b1;
                m_ones  = 0;
                m_beats = 0;
            end
        end
        c.out = ((m_ones % 2) == 0);
        c.fv  = fv;
        c.ok  = m_ok;
        c.err = m_err;
        cyc_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Four data beats (lowest byte first), optional gap after beat gap_at, then parity
    task automatic send_frame(input logic [31:0] beats, input logic [7:0] par, input bit om,
                              input int gap_at, input int ngap);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = beats[8*i +: 8];
            step(1'b1, b, om, 1'b0);
            if (i == gap_at) idle(ngap);
        end
        step(1'b1, par, om, 1'b0);
    endtask

    // Monitor: compares every driven cycle and pops frame results on frame_valid
    initial begin
        cyc_t e;
        frm_t f;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("out", 32'(bus.out), 32'(e.out));
                chk("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
                chk("frame_ok_held", 32'(bus.frame_ok), 32'(e.ok));
                chk("err_count_held", 32'(bus.err_count), 32'(e.err));
                if (bus.frame_valid === 1'b1) begin
                    if (frm_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got frame_valid=1, expected no frame");
                    end else begin
                        f = frm_q.pop_front();
                        chk("frame_ok", 32'(bus.frame_ok), 32'(f.ok));
                        chk("err_count", 32'(bus.err_count), 32'(f.err));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.odd_mode = 1'b0;
        model_reset();
        #2;
        chk("reset_out", 32'(bus.out), 32'd1);
        chk("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("reset_frame_ok", 32'(bus.frame_ok), 32'd0);
        chk("reset_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Good even frame, then bad even frame, then odd mode accepting parity 0
        send_frame(32'hFF_00_03_01, 8'h01, 1'b0, -1, 0);
        send_frame(32'hFF_00_03_01, 8'h00, 1'b0, -1, 0);
        send_frame(32'hFF_00_03_01, 8'h00, 1'b1, -1, 0);
        idle(1);
        // Three idle cycles between beats 2 and 3
        send_frame(32'hFF_00_03_01, 8'h01, 1'b0, 1, 3);
        // Abort on beat 3, then a full frame
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b1);
        send_frame(32'h80_00_11_01, 8'h00, 1'b1, -1, 0);
        // Five failing frames to reach saturation
        for (int k = 0; k < 5; k++) send_frame(32'h00_00_00_01, 8'h00, 1'b0, -1, 0);

        // Asynchronous reset mid-frame, between edges
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_out", 32'(bus.out), 32'd1);
        chk("async_reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("async_reset_err_count", 32'(bus.err_count), 32'd0);
        model_reset();
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send_frame(32'h0F_F0_AA_55, 8'h00, 1'b0, -1, 0);

        // Random beats, gaps, mode changes and occasional aborts
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 70), 8'($urandom()), 1'($urandom()),
                 ($urandom_range(99) < 3));
        end
        idle(3);
        @(posedge clk);
        #2;
        chk("frame_queue_drained", 32'(frm_q.size()), 32'd0);
        chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
